intc: RTL and testbench

- Peripheral-side interrupt controller that produces the `irq[CPU_IRQ_CH-1:0]` vector consumed by the CPU control block.
- Collects raw peripheral interrupt sources and qualifies each as level or rising-edge.
- Latches each source in a pending register, gates it with an enable register and drives the registered result to the CPU.
- Software configures, inspects and acknowledges sources through a bus slave port with `cs_`/`as_`/`rdy_` handshake.

---
 rtl/intc.sv | 132 +++++++++++++
 tb/tb_intc.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/intc.sv
// Peripheral interrupt controller: level/edge qualified sources, pending/enable masking,
// registered irq vector and a cs_/as_/rdy_ register port. Define INTC_SYNC_EN to add a 2-flop input synchronizer.
module intc #(
   parameter int CPU_IRQ_CH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cs_,
   input  logic                  as_,
   input  logic                  rw,
   input  logic [1:0]            addr,
   input  logic [31:0]           wr_data,
   output logic [31:0]           rd_data,
   output logic                  rdy_,
   input  logic [CPU_IRQ_CH-1:0] irq_src,
   output logic [CPU_IRQ_CH-1:0] irq
);

   typedef enum logic {IDLE, ACK} busState_t;

   busState_t             state_q;
   logic [CPU_IRQ_CH-1:0] s1_q;
   logic [CPU_IRQ_CH-1:0] sPrev_q;
   logic [CPU_IRQ_CH-1:0] pending_q, pending_d;
   logic [CPU_IRQ_CH-1:0] enable_q, enable_d;
   logic [CPU_IRQ_CH-1:0] edgeMode_q, edgeMode_d;
   logic [CPU_IRQ_CH-1:0] irq_q;
   logic [31:0]           rdData_q;
   logic                  rdy_q;

   logic [CPU_IRQ_CH-1:0] rise;
   logic [CPU_IRQ_CH-1:0] active;
   logic [CPU_IRQ_CH-1:0] w1c;
   logic [7:0]            vecIdx;
   logic                  vecValid;
   logic                  busReq;
   logic                  busWr;
   logic [31:0]           regRead;

`ifdef INTC_SYNC_EN
   logic [CPU_IRQ_CH-1:0] s0_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         s0_q <= '0;
         s1_q <= '0;
      end else begin
         s0_q <= irq_src;
         s1_q <= s0_q;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q <= '0;
      end else begin
         s1_q <= irq_src;
      end
   end
`endif

   always_comb begin
      active   = pending_q & enable_q;
      vecValid = |active;
      vecIdx   = 8'd0;
      for (int i = CPU_IRQ_CH - 1; i >= 0; i--) begin
         if (active[i]) vecIdx = 8'(i);
      end

      busReq = (state_q == IDLE) && !cs_ && !as_;
      busWr  = busReq && !rw;
      rise   = s1_q & ~sPrev_q;

      // Clears only touch edge-mode bits, and a coincident rise re-sets the bit.
      w1c        = (busWr && addr == 2'd0) ? (wr_data[CPU_IRQ_CH-1:0] & edgeMode_q) : '0;
      pending_d  = (edgeMode_q & ((pending_q & ~w1c) | rise)) | (~edgeMode_q & s1_q);
      enable_d   = (busWr && addr == 2'd1) ? wr_data[CPU_IRQ_CH-1:0] : enable_q;
      edgeMode_d = (busWr && addr == 2'd2) ? wr_data[CPU_IRQ_CH-1:0] : edgeMode_q;

      case (addr)
         2'd0:    regRead = 32'(pending_q);
         2'd1:    regRead = 32'(enable_q);
         2'd2:    regRead = 32'(edgeMode_q);
         default: regRead = {vecValid, 23'd0, vecIdx};
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         sPrev_q    <= '0;
         pending_q  <= '0;
         enable_q   <= '0;
         edgeMode_q <= '0;
         irq_q      <= '0;
         rdData_q   <= '0;
         rdy_q      <= 1'b1;
      end else begin
         sPrev_q    <= s1_q;
         pending_q  <= pending_d;
         enable_q   <= enable_d;
         edgeMode_q <= edgeMode_d;
         irq_q      <= active;
         case (state_q)
            IDLE: begin
               if (busReq) begin
                  state_q  <= ACK;
                  rdy_q    <= 1'b0;
                  rdData_q <= rw ? regRead : 32'd0;
               end else begin
                  rdy_q    <= 1'b1;
                  rdData_q <= 32'd0;
               end
            end
            ACK: begin
               state_q  <= IDLE;
               rdy_q    <= 1'b1;
               rdData_q <= 32'd0;
            end
            default: begin
               state_q <= IDLE;
               rdy_q   <= 1'b1;
            end
         endcase
      end
   end

   assign irq     = irq_q;
   assign rd_data = rdData_q;
   assign rdy_    = rdy_q;

endmodule

// File: tb/tb_intc.sv
// Scoreboarded bench for intc: bus reads queue expected data, popped when rdy_ acknowledges.
module tb_intc;

   localparam int N = 8;
`ifdef INTC_SYNC_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 3;
`endif

   logic          clk;
   logic          reset;
   logic          cs_;
   logic          as_;
   logic          rw;
   logic [1:0]    addr;
   logic [31:0]   wr_data;
   logic [31:0]   rd_data;
   logic          rdy_;
   logic [N-1:0]  irq_src;
   logic [N-1:0]  irq;

   int checks = 0;
   int passes = 0;
   logic [31:0] expQ[$];
   string       tagQ[$];

   intc #(.CPU_IRQ_CH(N)) dut (
      .clk(clk), .reset(reset), .cs_(cs_), .as_(as_), .rw(rw), .addr(addr),
      .wr_data(wr_data), .rd_data(rd_data), .rdy_(rdy_), .irq_src(irq_src), .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      else passes++;
   endtask

   // Called on a negedge; returns on the negedge after the FSM is back in IDLE.
   task automatic applyStimulus(input logic isRead, input logic [1:0] a, input logic [31:0] wd,
                                input logic [31:0] expRd, input string tag);
      logic [31:0] e;
      string t;
      bit acked;
      expQ.push_back(isRead ? expRd : 32'd0);
      tagQ.push_back(tag);
      cs_ = 1'b0; as_ = 1'b0; rw = isRead; addr = a; wr_data = wd;
      acked = 0;
      for (int k = 0; k < 8 && !acked; k++) begin
         @(posedge clk); @(negedge clk);
         if (!rdy_) acked = 1;
      end
      e = expQ.pop_front();
      t = tagQ.pop_front();
      if (acked) checkOutput(t, rd_data, e);
      else checkOutput({t, "_rdy"}, 32'(rdy_), 32'd0);
      cs_ = 1'b1; as_ = 1'b1; wr_data = 32'd0;
      @(posedge clk); @(negedge clk);
   endtask

   task automatic idleCycles(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk); @(negedge clk);
      end
   endtask

   initial begin
      reset = 1'b1; cs_ = 1'b1; as_ = 1'b1; rw = 1'b1; addr = 2'd0; wr_data = 32'd0;
      irq_src = 8'hFF;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_irq", 32'(irq), 32'd0);
      checkOutput("rst_rdy", 32'(rdy_), 32'd1);
      checkOutput("rst_rddata", rd_data, 32'd0);
      reset = 1'b0;
      applyStimulus(1'b1, 2'd0, 32'd0, 32'd0, "rst_pend_first");
      applyStimulus(1'b1, 2'd0, 32'd0, 32'hFF, "rst_pend_level");
      irq_src = 8'h00;
      applyStimulus(1'b1, 2'd1, 32'd0, 32'd0, "rst_enable");
      applyStimulus(1'b1, 2'd2, 32'd0, 32'd0, "rst_edge");
      applyStimulus(1'b1, 2'd3, 32'd0, 32'd0, "rst_vector");
      idleCycles(4);

      // Level path
      applyStimulus(1'b0, 2'd1, 32'h04, 32'd0, "lvl_wr_en");
      applyStimulus(1'b0, 2'd2, 32'h00, 32'd0, "lvl_wr_edge");
      irq_src = 8'h04;
      for (int k = 1; k <= LAT; k++) begin
         @(posedge clk); @(negedge clk);
         if (k >= LAT - 1) checkOutput($sformatf("lvl_rise_e%0d", k), 32'(irq), (k == LAT) ? 32'h04 : 32'h0);
      end
      applyStimulus(1'b0, 2'd0, 32'h04, 32'd0, "lvl_w1c");
      applyStimulus(1'b1, 2'd0, 32'd0, 32'h04, "lvl_pend_after_w1c");
      checkOutput("lvl_irq_after_w1c", 32'(irq), 32'h04);
      irq_src = 8'h00;
      for (int k = 1; k <= LAT; k++) begin
         @(posedge clk); @(negedge clk);
         if (k >= LAT - 1) checkOutput($sformatf("lvl_fall_e%0d", k), 32'(irq), (k == LAT) ? 32'h0 : 32'h04);
      end

      // Edge path
      applyStimulus(1'b0, 2'd2, 32'h01, 32'd0, "edg_wr_edge");
      applyStimulus(1'b0, 2'd1, 32'h01, 32'd0, "edg_wr_en");
      irq_src = 8'h01;
      idleCycles(1);
      irq_src = 8'h00;
      idleCycles(LAT + 1);
      checkOutput("edg_irq_held", 32'(irq), 32'h01);
      applyStimulus(1'b1, 2'd0, 32'd0, 32'h1, "edg_pend");
      applyStimulus(1'b0, 2'd0, 32'h1, 32'd0, "edg_w1c");
      checkOutput("edg_irq_cleared", 32'(irq), 32'h0);
      applyStimulus(1'b1, 2'd0, 32'd0, 32'h0, "edg_pend_cleared");

      // Set beats clear: W1C lands on the edge where the rise is seen
      irq_src = 8'h01;
      idleCycles(LAT - 2);
      applyStimulus(1'b0, 2'd0, 32'h1, 32'd0, "sbc_w1c");
      applyStimulus(1'b1, 2'd0, 32'd0, 32'h1, "sbc_pend");
      irq_src = 8'h00;
      idleCycles(3);
      applyStimulus(1'b0, 2'd0, 32'h1, 32'd0, "sbc_w1c2");
      applyStimulus(1'b1, 2'd0, 32'd0, 32'h0, "sbc_pend_cleared");

      // Vector encoding
      applyStimulus(1'b0, 2'd1, 32'hFF, 32'd0, "vec_wr_en");
      applyStimulus(1'b0, 2'd2, 32'hFF, 32'd0, "vec_wr_edge");
      irq_src = 8'h28;
      idleCycles(1);
      irq_src = 8'h00;
      idleCycles(LAT + 1);
      applyStimulus(1'b1, 2'd3, 32'd0, 32'h8000_0003, "vec_idx3");
      applyStimulus(1'b0, 2'd0, 32'h08, 32'd0, "vec_clr3");
      applyStimulus(1'b1, 2'd3, 32'd0, 32'h8000_0005, "vec_idx5");
      applyStimulus(1'b0, 2'd3, 32'hFFFF_FFFF, 32'd0, "vec_wr_ignored");
      applyStimulus(1'b1, 2'd3, 32'd0, 32'h8000_0005, "vec_idx5_again");
      applyStimulus(1'b0, 2'd0, 32'h20, 32'd0, "vec_clr5");
      applyStimulus(1'b1, 2'd3, 32'd0, 32'h0, "vec_none");

      // Handshake with a held request
      cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = 2'd1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); @(negedge clk);
         checkOutput($sformatf("hs_rdy_c%0d", k), 32'(rdy_), (k == 1) ? 32'd1 : 32'd0);
         checkOutput($sformatf("hs_data_c%0d", k), rd_data, (k == 1) ? 32'd0 : 32'hFF);
      end
      cs_ = 1'b1; as_ = 1'b1;
      @(posedge clk); @(negedge clk);
      checkOutput("hs_rdy_release", 32'(rdy_), 32'd1);
      checkOutput("hs_data_release", rd_data, 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
